// File: rtl/vector_result_writeback.sv
//------------------------------------------------------------------------------
// Module   : vector_result_writeback
// Purpose  : Turns a functional-unit result stream into Vi element writes or a
//            single VM write, with a running chain count for dependent issue.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vector_result_writeback #(
   parameter int LATENCY = 2,
   parameter int WIDTH   = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [2:0]       i_i,
   input  logic [6:0]       i_vl,
   input  logic             i_mask_mode,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_we,
   output logic [2:0]       o_wsel,
   output logic [5:0]       o_waddr,
   output logic [WIDTH-1:0] o_wdata,
   output logic             o_vm_we,
   output logic [WIDTH-1:0] o_vm_data,
   output logic [6:0]       o_chain_count,
   output logic             o_busy,
   output logic             o_done
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FILL   = 2'd1;
   localparam logic [1:0] S_STREAM = 2'd2;

   // FILL spends LATENCY-1 clocks; with LATENCY=1 it is skipped entirely.
   localparam logic       C_DIRECT    = (LATENCY == 1);
   localparam logic [3:0] C_FILL_LAST = 4'(LATENCY - 2);

   logic [1:0]       r_state;
   logic [3:0]       r_fill;
   logic [5:0]       r_k;
   logic [6:0]       r_n;
   logic [2:0]       r_i;
   logic             r_mask;

   logic             r_we;
   logic [2:0]       r_wsel;
   logic [5:0]       r_waddr;
   logic [WIDTH-1:0] r_wdata;
   logic             r_vm_we;
   logic [WIDTH-1:0] r_vm_data;
   logic [6:0]       r_chain;
   logic             r_done;

   logic [6:0]       w_vl_eff;
   logic             w_last;

   // A length of 0 or anything above 64 means a full 64-element vector.
   assign w_vl_eff = ((i_vl == 7'd0) || (i_vl > 7'd64)) ? 7'd64 : i_vl;
   assign w_last   = ({1'b0, r_k} == (r_n - 7'd1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_fill    <= 4'd0;
         r_k       <= 6'd0;
         r_n       <= 7'd0;
         r_i       <= 3'd0;
         r_mask    <= 1'b0;
         r_we      <= 1'b0;
         r_wsel    <= 3'd0;
         r_waddr   <= 6'd0;
         r_wdata   <= '0;
         r_vm_we   <= 1'b0;
         r_vm_data <= '0;
         r_chain   <= 7'd0;
         r_done    <= 1'b0;
      end else begin
         r_we    <= 1'b0;
         r_vm_we <= 1'b0;
         r_done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_i     <= i_i;
                  r_mask  <= i_mask_mode;
                  r_n     <= w_vl_eff;
                  r_chain <= 7'd0;
                  r_fill  <= 4'd0;
                  r_k     <= 6'd0;
                  r_state <= C_DIRECT ? S_STREAM : S_FILL;
               end
            end
            S_FILL: begin
               if (r_fill == C_FILL_LAST) begin
                  r_state <= S_STREAM;
               end else begin
                  r_fill <= r_fill + 4'd1;
               end
            end
            S_STREAM: begin
               // Mask results accumulate in the unit, so only the final sample matters.
               if (!r_mask) begin
                  r_we    <= 1'b1;
                  r_wsel  <= r_i;
                  r_waddr <= r_k;
                  r_wdata <= i_data;
                  r_chain <= {1'b0, r_k} + 7'd1;
               end else if (w_last) begin
                  r_vm_we   <= 1'b1;
                  r_vm_data <= i_data;
               end
               if (w_last) begin
                  r_done  <= 1'b1;
                  r_k     <= 6'd0;
                  r_state <= S_IDLE;
               end else begin
                  r_k <= r_k + 6'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_we          = r_we;
   assign o_wsel        = r_wsel;
   assign o_waddr       = r_waddr;
   assign o_wdata       = r_wdata;
   assign o_vm_we       = r_vm_we;
   assign o_vm_data     = r_vm_data;
   assign o_chain_count = r_chain;
   assign o_busy        = (r_state != S_IDLE);
   assign o_done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_vector_result_writeback.sv
//------------------------------------------------------------------------------
// Module   : tb_vector_result_writeback
// Purpose  : Scoreboard bench for vector_result_writeback.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_vector_result_writeback;

   localparam int LAT = 2;
   localparam int W   = 64;
   localparam logic [63:0] C_JUNK = 64'hDEAD_BEEF_0BAD_F00D;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_start;
   logic [2:0]    i_i;
   logic [6:0]    i_vl;
   logic          i_mask_mode;
   logic [W-1:0]  i_data;
   logic          o_we;
   logic [2:0]    o_wsel;
   logic [5:0]    o_waddr;
   logic [W-1:0]  o_wdata;
   logic          o_vm_we;
   logic [W-1:0]  o_vm_data;
   logic [6:0]    o_chain_count;
   logic          o_busy;
   logic          o_done;

   vector_result_writeback #(.LATENCY(LAT), .WIDTH(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_start       (i_start),
      .i_i           (i_i),
      .i_vl          (i_vl),
      .i_mask_mode   (i_mask_mode),
      .i_data        (i_data),
      .o_we          (o_we),
      .o_wsel        (o_wsel),
      .o_waddr       (o_waddr),
      .o_wdata       (o_wdata),
      .o_vm_we       (o_vm_we),
      .o_vm_data     (o_vm_data),
      .o_chain_count (o_chain_count),
      .o_busy        (o_busy),
      .o_done        (o_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic        we;
      logic [2:0]  wsel;
      logic [5:0]  waddr;
      logic [63:0] wdata;
      logic        vm_we;
      logic [63:0] vm_data;
      logic [6:0]  chain;
      logic        done;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   logic [63:0] dat[64];

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Monitor: every strobe the DUT presents must match the head of the queue.
   always @(negedge clk) begin
      if (o_we === 1'b1 || o_vm_we === 1'b1 || o_done === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_strobe", {61'd0, o_we, o_vm_we, o_done}, 64'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
            chk("we", {63'd0, o_we}, {63'd0, e.we});
            chk("vm_we", {63'd0, o_vm_we}, {63'd0, e.vm_we});
            chk("done", {63'd0, o_done}, {63'd0, e.done});
            chk("chain_count", {57'd0, o_chain_count}, {57'd0, e.chain});
            if (e.we) begin
               chk("wsel", {61'd0, o_wsel}, {61'd0, e.wsel});
               chk("waddr", {58'd0, o_waddr}, {58'd0, e.waddr});
               chk("wdata", o_wdata, e.wdata);
            end
            if (e.vm_we) chk("vm_data", o_vm_data, e.vm_data);
         end
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_we"}, {63'd0, o_we}, 64'd0);
      chk({tag, "_wsel"}, {61'd0, o_wsel}, 64'd0);
      chk({tag, "_waddr"}, {58'd0, o_waddr}, 64'd0);
      chk({tag, "_wdata"}, o_wdata, 64'd0);
      chk({tag, "_vm_we"}, {63'd0, o_vm_we}, 64'd0);
      chk({tag, "_vm_data"}, o_vm_data, 64'd0);
      chk({tag, "_chain"}, {57'd0, o_chain_count}, 64'd0);
      chk({tag, "_busy"}, {63'd0, o_busy}, 64'd0);
      chk({tag, "_done"}, {63'd0, o_done}, 64'd0);
   endtask

   // Called at a negedge; returns at the negedge of the o_done cycle (or after reset).
   task automatic issue(input logic [2:0] ii, input logic [6:0] vl, input logic m,
                        input int n, input int extra_at, input int rst_at);
      int   e0;
      int   nw;
      exp_t e;
      e0 = cyc + 1;
      nw = (rst_at >= 0) ? (rst_at - LAT) : n;
      for (int k = 0; k < nw; k++) begin
         e.cyc = e0 + LAT + k;
         e.wsel = ii; e.waddr = 6'(k); e.wdata = dat[k];
         e.vm_data = dat[k]; e.done = (k == n - 1);
         if (!m) begin
            e.we = 1'b1; e.vm_we = 1'b0; e.chain = 7'(k + 1);
            q.push_back(e);
         end else if (k == n - 1) begin
            e.we = 1'b0; e.vm_we = 1'b1; e.chain = 7'd0;
            q.push_back(e);
         end
      end
      i_start = 1'b1; i_i = ii; i_vl = vl; i_mask_mode = m; i_data = C_JUNK;
      for (int t = 1; t <= LAT + n - 1; t++) begin
         @(negedge clk);
         if (t == 1) chk("busy_running", {63'd0, o_busy}, 64'd1);
         i_start = (t == extra_at);
         if (t == extra_at) begin
            i_i = 3'd7; i_vl = 7'd1; i_mask_mode = 1'b1;
         end
         i_data = (t >= LAT) ? dat[t - LAT] : C_JUNK;
         if (t == rst_at) begin
            rst = 1'b1;
            break;
         end
      end
      @(negedge clk);
      i_start = 1'b0;
      i_data  = C_JUNK;
      if (rst_at >= 0) begin
         rst = 1'b0;
      end else begin
         chk("busy_in_done_cycle", {63'd0, o_busy}, 64'd0);
         chk("final_chain", {57'd0, o_chain_count}, m ? 64'd0 : 64'(n));
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; i_start = 1'b0; i_i = 3'd0; i_vl = 7'd0; i_mask_mode = 1'b0; i_data = '0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      idle(1);

      // Basic Vi write
      dat[0] = 64'h11; dat[1] = 64'h22; dat[2] = 64'h33; dat[3] = 64'h44;
      issue(3'd3, 7'd4, 1'b0, 4, -1, -1);
      idle(3);

      // Mask mode, full length: only the last accumulated value reaches VM
      for (int k = 0; k < 64; k++) dat[k] = (k == 63) ? 64'hFFFF_0000_0000_0001 : 64'(k * 3 + 1);
      issue(3'd1, 7'd64, 1'b1, 64, -1, -1);
      idle(3);

      // VL edge cases
      for (int k = 0; k < 64; k++) dat[k] = 64'hA5A5_0000_0000_0000 | 64'(k);
      issue(3'd2, 7'd0, 1'b0, 64, -1, -1);
      idle(2);
      for (int k = 0; k < 64; k++) dat[k] = 64'h5A00_0000_0000_0000 | 64'(k << 4);
      issue(3'd4, 7'd100, 1'b0, 64, -1, -1);
      idle(2);
      dat[0] = 64'h77;
      issue(3'd6, 7'd1, 1'b0, 1, -1, -1);
      idle(2);

      // i_start while busy is ignored
      for (int k = 0; k < 8; k++) dat[k] = 64'hC0DE_0000_0000_0000 + 64'(k);
      issue(3'd1, 7'd8, 1'b0, 8, 3, -1);
      idle(6);
      chk("no_second_run_busy", {63'd0, o_busy}, 64'd0);

      // Reset mid-run
      for (int k = 0; k < 16; k++) dat[k] = 64'hBEEF_0000_0000_0000 + 64'(k);
      issue(3'd2, 7'd16, 1'b0, 16, -1, 4);
      check_zero("midreset");
      idle(20);
      dat[0] = 64'h1; dat[1] = 64'h2; dat[2] = 64'h3; dat[3] = 64'h4;
      issue(3'd3, 7'd4, 1'b0, 4, -1, -1);
      idle(3);

      // Back-to-back: second start presented in the o_done cycle
      dat[0] = 64'hAA; dat[1] = 64'hBB; dat[2] = 64'hCC; dat[3] = 64'hDD;
      issue(3'd0, 7'd4, 1'b0, 4, -1, -1);
      dat[0] = 64'h5550; dat[1] = 64'h5551;
      issue(3'd5, 7'd2, 1'b0, 2, -1, -1);
      idle(6);

      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
